// File: rtl/nanorv32_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : nanorv32_fetch_unit
// Brief    : Prefetching instruction fetch unit with a DEPTH-entry queue,
//            pipelined in-order code-memory requests and discard-based redirects.
// Revision : 1.0
// ============================================================================

module nanorv32_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              codemem_req,
  output logic [ADDR_W-1:0] codemem_addr,
  input  logic              codemem_gnt,
  input  logic              codemem_rvalid,
  input  logic [DATA_W-1:0] codemem_rdata,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              stall,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned INF_W = $clog2(2 * DEPTH) + 1;
  localparam int unsigned SUM_W = INF_W + 1;

  localparam logic [ADDR_W-1:0] c_STEP       = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [CNT_W-1:0]  c_DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [INF_W-1:0]  c_MAX_INF    = INF_W'(2 * DEPTH);
  localparam logic [SUM_W-1:0]  c_DEPTH_SUM  = SUM_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] rpc_q, rpc_d;
  logic [INF_W-1:0]  inflight_q, inflight_d;
  logic [INF_W-1:0]  discard_q, discard_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

  logic              w_rsp;
  logic              w_keep;
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic              w_credit;
  logic [ADDR_W-1:0] w_target;
  logic [SUM_W-1:0]  w_outstanding;

  // Slots already promised to kept responses; issuing only below DEPTH means
  // every response that is not discarded is guaranteed a queue entry.
  assign w_outstanding = SUM_W'(count_q) + SUM_W'(inflight_q) - SUM_W'(discard_q);
  assign w_credit      = (w_outstanding < c_DEPTH_SUM) && (inflight_q < c_MAX_INF);
  assign w_target      = flush_pc & c_ALIGN_MASK;

  assign codemem_req  = (state_q == ST_RUN) && !stall && !flush && w_credit;
  assign codemem_addr = fpc_q;
  assign w_issue      = codemem_req && codemem_gnt;

  assign w_rsp  = codemem_rvalid && (inflight_q != '0);
  assign w_keep = w_rsp && (discard_q == '0) && !flush;
  assign w_pop  = inst_valid && inst_ready;
  assign w_push = w_keep && ((count_q != c_DEPTH_CNT) || w_pop);

  assign inst_valid = (count_q != '0);
  assign inst_data  = data_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign busy       = (inflight_q != '0);

  always_comb begin
    fpc_d      = fpc_q;
    rpc_d      = rpc_q;
    discard_d  = discard_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = inflight_q + INF_W'(w_issue) - INF_W'(w_rsp);
    if (flush) begin
      fpc_d     = w_target;
      rpc_d     = w_target;
      discard_d = inflight_q - INF_W'(w_rsp);
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end else begin
      if (w_issue) fpc_d = fpc_q + c_STEP;
      if (w_keep) rpc_d = rpc_q + c_STEP;
      if (w_rsp && (discard_q != '0)) discard_d = discard_q - INF_W'(1);
      if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
    end else begin
      case (state_q)
        ST_RESET: state_q <= ST_RUN;
        ST_RUN:   state_q <= ST_RUN;
        default:  state_q <= ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q      <= RESET_PC;
      rpc_q      <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fpc_q      <= fpc_d;
      rpc_q      <= rpc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage is cleared so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (w_push) begin
      data_mem_q[wr_ptr_q] <= codemem_rdata;
      pc_mem_q[wr_ptr_q]   <= rpc_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nanorv32_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_nanorv32_fetch_unit
// Brief    : Randomized scoreboard bench for nanorv32_fetch_unit with an
//            in-order variable-latency code memory model.
// Revision : 1.0
// ============================================================================

module tb_nanorv32_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        codemem_req;
  logic [31:0] codemem_addr;
  logic        codemem_gnt = 1'b0;
  logic        codemem_rvalid = 1'b0;
  logic [31:0] codemem_rdata = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        stall = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        busy;

  always #5 clk = ~clk;

  nanorv32_fetch_unit #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .codemem_req   (codemem_req),
    .codemem_addr  (codemem_addr),
    .codemem_gnt   (codemem_gnt),
    .codemem_rvalid(codemem_rvalid),
    .codemem_rdata (codemem_rdata),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .stall         (stall),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .busy          (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  // Reference model: after reset or a redirect to T the consumer must see
  // exactly T, T+4, T+8, ... (mod 2^32) with the memory word at each address.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } pair_t;
  pair_t exp_q[$];

  task automatic load_segment(input logic [31:0] target);
    logic [31:0] pc;
    pc = target & 32'hFFFF_FFFC;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back('{pc, memfn(pc)});
      pc = pc + 32'd4;
    end
  endtask

  // Code memory model: in-order responses, one per cycle, per-request latency.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t pend[$];

  int          cyc = 0;
  int          gnt_prob = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  int          gnt_budget = -1;
  int          n_accepted = 0;
  bit          track_next = 1'b0;
  bit          saw_wrap = 1'b0;
  bit          hold_valid = 1'b0;
  logic [31:0] tracked_addr = '0;
  logic [31:0] last_acc = '0;
  logic [31:0] hold_addr = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    int oust;
    bit acc;
    #1;
    if (!rst_n) begin
      pend.delete();
      codemem_rvalid = 1'b0;
      codemem_rdata  = '0;
      codemem_gnt    = 1'b0;
      hold_valid     = 1'b0;
    end else begin
      codemem_gnt = (gnt_budget != 0) && ($urandom_range(99) < gnt_prob);
      if (pend.size() > 0 && cyc >= pend[0].due) begin
        codemem_rvalid = 1'b1;
        codemem_rdata  = memfn(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        codemem_rvalid = 1'b0;
        codemem_rdata  = $urandom;
      end
      #1;
      if (codemem_req && hold_valid) check("req_addr_hold", codemem_addr, hold_addr);
      acc = codemem_req && codemem_gnt;
      if (acc) begin
        pend.push_back('{codemem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
        n_accepted++;
        if (gnt_budget > 0) gnt_budget--;
        if (track_next) begin
          tracked_addr = codemem_addr;
          track_next   = 1'b0;
        end
        if (codemem_addr == 32'h0 && last_acc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
        last_acc   = codemem_addr;
        hold_valid = 1'b0;
      end else if (codemem_req) begin
        hold_valid = 1'b1;
        hold_addr  = codemem_addr;
      end
      if (flush) hold_valid = 1'b0;
      oust = pend.size() - int'(acc) + int'(codemem_rvalid);
      check("busy", busy, oust != 0);
      check("inflight_bound", oust <= 2 * DEPTH, 1);
      check("queue_bound", dut.count_q <= DEPTH, 1);
    end
  end

  // Monitor: pops one expected pair per consumer handshake.
  int n_delivered = 0;

  always @(negedge clk) begin
    pair_t e;
    #3;
    if (rst_n && inst_valid && inst_ready) begin
      n_delivered++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc 0x%0h with no expected entry", inst_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", inst_pc, e.pc);
        check("sb_data", inst_data, e.data);
      end
    end
  end

  task automatic do_flush(input logic [31:0] t);
    flush      = 1'b1;
    flush_pc   = t;
    track_next = 1'b1;
    @(posedge clk);
    #1;
    load_segment(t);
    @(negedge clk);
    flush = 1'b0;
    check("flush_empty", inst_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark;
    int nf;
    int i;

    repeat (3) @(negedge clk);
    check("rst_req", codemem_req, 0);
    check("rst_addr", codemem_addr, 32'h0);
    check("rst_valid", inst_valid, 0);
    check("rst_data", inst_data, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_busy", busy, 0);

    // Reset release: one idle cycle, then 3-cycle first-instruction latency.
    load_segment(32'h0);
    rst_n = 1'b1;
    #1 check("req_in_reset_state", codemem_req, 0);
    @(negedge clk);
    #1 check("req_first_run", codemem_req, 1);
    check("valid_c1", inst_valid, 0);
    @(negedge clk);
    check("valid_c2", inst_valid, 0);
    @(negedge clk);
    check("valid_c3", inst_valid, 1);
    check("first_pc", inst_pc, 32'h0);
    repeat (30) begin
      @(negedge clk);
      check("no_bubble", inst_valid, 1);
    end

    // Consumer blocked: exactly DEPTH requests, then fetch stops at 0x10.
    @(negedge clk);
    rst_n = 1'b0;
    inst_ready = 1'b0;
    n_accepted = 0;
    @(negedge clk);
    load_segment(32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("accepted_when_blocked", n_accepted, DEPTH);
    check("req_blocked", codemem_req, 0);
    check("addr_held", codemem_addr, 32'h10);
    check("head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    repeat (12) @(negedge clk);

    // Latency 3, redirect while two requests are outstanding.
    @(negedge clk);
    rst_n = 1'b0;
    lat_min = 3;
    lat_max = 3;
    gnt_budget = 2;
    n_accepted = 0;
    @(negedge clk);
    load_segment(32'h0);
    rst_n = 1'b1;
    i = 0;
    while (n_accepted < 2 && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("two_inflight", n_accepted, 2);
    check("busy_inflight", busy, 1);
    gnt_budget = -1;
    do_flush(32'h103);
    repeat (10) @(negedge clk);
    check("redirect_addr", tracked_addr, 32'h100);
    check("discard_zero", dut.discard_q, 0);

    // Redirect coinciding with a returning response and a consumer handshake.
    lat_min = 1;
    lat_max = 1;
    repeat (15) @(negedge clk);
    check("valid_at_flush", inst_valid, 1);
    do_flush(32'h200);
    repeat (10) @(negedge clk);

    // Address wrap past the top of the address space.
    saw_wrap = 1'b0;
    do_flush(32'hFFFF_FFF9);
    repeat (20) @(negedge clk);
    check("addr_wrap", saw_wrap, 1);

    // Random grants, latencies, stalls, consumer readiness and redirects.
    gnt_prob = 50;
    lat_max  = 4;
    nf = int'($urandom_range(50, 15));
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      stall      = ($urandom_range(99) < 10);
      inst_ready = ($urandom_range(99) < 70);
      nf--;
      if (nf == 0) begin
        do_flush($urandom & 32'h000F_FFFF);
        nf = int'($urandom_range(50, 15));
      end
    end

    // Drain: full-rate flow must resume.
    gnt_prob   = 100;
    lat_max    = 1;
    stall      = 1'b0;
    inst_ready = 1'b1;
    mark = n_delivered;
    repeat (40) @(negedge clk);
    check("drain_progress", (n_delivered - mark) >= 30, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
